prefetch_fetch_unit: RTL and testbench
======================================

# prefetch_fetch_unit

Parametrised instruction-fetch front end that replaces the fixed PC register, PC+4 adder and zero-latency instruction-memory lookup of the single-cycle datapath. It generates sequential fetch addresses, talks to a variable-latency instruction memory through a request/response handshake and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. Branch/jump redirects flush the queue and discard any stale in-flight response. It feeds the decode stage of the pipelined core.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- INSTR_WIDTH, 32, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- Clk  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  one-cycle fetch request; memory always accepts
- imem_addr  out  ADDR_WIDTH  fetch address, valid with imem_req
- imem_rvalid  in  1  response valid, ≥1 cycle after the matching imem_req
- imem_rdata  in  INSTR_WIDTH  instruction word, valid with imem_rvalid
- branch_taken  in  1  redirect strobe, one cycle
- branch_target  in  ADDR_WIDTH  redirect address
- instr_valid  out  1  queue head holds a valid instruction
- instr_ready  in  1  decode consumes head when instr_valid is also high
- instr  out  INSTR_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  PC of head instruction
- fifo_count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- State: fetch_pc, req_pc, outstanding flag, drop flag, queue (entry = {pc, instr}).
- Issue condition: !outstanding && (fifo_count + outstanding) < DEPTH && !branch_taken. When true, imem_req=1, imem_addr=fetch_pc; at edge: req_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps modulo 2^ADDR_WIDTH), outstanding←1.
- At most one request outstanding. Credit rule guarantees a push never finds the queue full.
- Response (imem_rvalid): outstanding←0. If drop=1: discard, drop←0. Else push {req_pc, imem_rdata}.
- Pop: instr_valid && instr_ready removes head. Push and pop in the same cycle: occupancy unchanged, both take effect.
- Redirect (branch_taken) has priority over push, pop and issue: queue flushed (count←0); fetch_pc←{branch_target[ADDR_WIDTH-1:2], 2'b00}; no request that cycle; if outstanding && !imem_rvalid, drop←1; a response arriving in the redirect cycle is discarded and clears outstanding.
- Back-to-back redirects: the last one wins; drop stays set until the single stale response returns.
- instr/instr_pc are first-word fall-through from the head; instr_valid = (fifo_count != 0).
- Combinational outputs driven when invalid: instr/instr_pc show head storage, value don't-care.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, fifo_count=0, outstanding=0, drop=0, fetch_pc=RESET_PC.
- First imem_req in the first cycle after Reset deasserts.
- Minimum fetch-to-decode latency: req at cycle t, rvalid at t+1, instr_valid at t+2.
- Steady state with 1-cycle memory: one request every 2 cycles (single-outstanding rule).
- After redirect at cycle r: earliest new imem_req at r+1 with imem_addr = aligned target.
- Reset mid-operation clears outstanding/drop; the instruction memory shares Reset and must abandon its pending response.

## Structure
- Shared package: fetch_entry_t {pc, instr}, constant PC_INCR=4, default RESET_PC.
- One sub-module: fetch_fifo — synchronous FWFT FIFO, parameters WIDTH/DEPTH, ports push/pop/flush/count, flush dominant over push/pop.
- Top level holds PC, outstanding/drop flags and issue/credit logic.

## Test plan
- Reset, 1-cycle memory returning word = addr, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8; first instr_valid 2 cycles after first imem_req.
- instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0–0xC), fifo_count=4, imem_req stays 0; raise ready -> fetch resumes at 0x10.
- Redirect to 0x103 while request for 0x8 outstanding (3-cycle latency) -> stale 0x8 response dropped, queue empty, next imem_addr=0x100, instr_pc=0x100 first.
- Redirect in same cycle as imem_rvalid -> response discarded, no push, drop stays 0, next request 1 cycle later.
- fetch_pc near 0xFFFFFFFC -> next address 0x00000000 (wrap).
- Reset asserted with queue at 3 entries and a request outstanding -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package prefetch_fetch_unit_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;
  localparam int unsigned PC_INCR         = 4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fetch_unit_if.sv
// Bundles the instruction-memory, redirect and decode-side signals of the fetch unit.
interface prefetch_fetch_unit_if
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH       = 4
);

  logic                     imem_req;
  logic [ADDR_WIDTH-1:0]    imem_addr;
  logic                     imem_rvalid;
  logic [INSTR_WIDTH-1:0]   imem_rdata;
  logic                     branch_taken;
  logic [ADDR_WIDTH-1:0]    branch_target;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [INSTR_WIDTH-1:0]   instr;
  logic [ADDR_WIDTH-1:0]    instr_pc;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    input  imem_rvalid, imem_rdata, branch_taken, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    output imem_rvalid, imem_rdata, branch_taken, branch_target, instr_ready
  );

endinterface

// File: rtl/prefetch_fetch_unit_fifo.sv
// First-word-fall-through prefetch queue; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r    <= '{default: '0};
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding memory
// requests with credit-based issue, and redirect flush with stale-response drop.
module prefetch_fetch_unit
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input logic                  clk,
  input logic                  rst,
  prefetch_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_r, fetch_pc_s;
  logic [ADDR_WIDTH-1:0] req_pc_r, req_pc_s;
  logic                  outstanding_r, outstanding_s;
  logic                  drop_r, drop_s;
  logic                  issue_s, push_s, pop_s, valid_s;
  logic [CW-1:0]         count_s;
  entry_t                push_entry_s, head_entry_s;

  assign valid_s = (count_s != CW'(0));
  // Holding back while reset is high keeps imem_req low asynchronously.
  assign issue_s = !rst && !outstanding_r && !bus.branch_taken &&
                   ((count_s + CW'(outstanding_r)) < CW'(DEPTH));
  assign push_s  = bus.imem_rvalid && !drop_r && !bus.branch_taken;
  assign pop_s   = valid_s && bus.instr_ready && !bus.branch_taken;

  assign push_entry_s = '{pc: req_pc_r, instr: bus.imem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.branch_taken),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_entry_s),
    .count     (count_s)
  );

  // Next PC and request-tracking flags; a redirect overrides both response and issue.
  always_comb begin
    fetch_pc_s    = fetch_pc_r;
    req_pc_s      = req_pc_r;
    outstanding_s = outstanding_r;
    drop_s        = drop_r;
    if (bus.branch_taken) begin
      fetch_pc_s    = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
      outstanding_s = outstanding_r && !bus.imem_rvalid;
      drop_s        = outstanding_r && !bus.imem_rvalid;
    end else if (bus.imem_rvalid) begin
      outstanding_s = 1'b0;
      drop_s        = 1'b0;
    end else if (issue_s) begin
      fetch_pc_s    = fetch_pc_r + ADDR_WIDTH'(PC_INCR);
      req_pc_s      = fetch_pc_r;
      outstanding_s = 1'b1;
    end else begin
      outstanding_s = outstanding_r;
    end
  end

  // PC and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      req_pc_r      <= RESET_PC;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      fetch_pc_r    <= fetch_pc_s;
      req_pc_r      <= req_pc_s;
      outstanding_r <= outstanding_s;
      drop_r        <= drop_s;
    end
  end

  assign bus.imem_req    = issue_s;
  assign bus.imem_addr   = fetch_pc_r;
  assign bus.instr_valid = valid_s;
  assign bus.instr       = head_entry_s.instr;
  assign bus.instr_pc    = head_entry_s.pc;
  assign bus.fifo_count  = count_s;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Randomized bench for prefetch_fetch_unit against an epoch-tagged queue model.
module tb_prefetch_fetch_unit;
  import prefetch_fetch_unit_pkg::*;

  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prefetch_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus();

  prefetch_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: the queue as seen by decode, plus one in-flight request tagged with the
  // redirect epoch it was issued in; a response from an older epoch is worthless.
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc, m_req_addr;
  bit           m_inflight;
  int           m_epoch, m_req_epoch;

  // Instruction memory behaviour driven by the bench.
  bit           mem_busy;
  int           mem_lat;
  logic [31:0]  mem_addr, salt;
  int           lat_min, lat_max;

  int cyc, first_req, first_valid;
  bit found;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_imem_req"}, bus.imem_req, 1'b0);
    check_val({tag, "_imem_addr"}, bus.imem_addr, RPC);
    check_val({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
    check_val({tag, "_fifo_count"}, bus.fifo_count, 0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = RPC;
    m_inflight = 1'b0;
    m_epoch++;
    mem_busy   = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model and memory.
  task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
    bit          v, exp_req, pop;
    logic [31:0] data;
    v    = mem_busy && (mem_lat == 0);
    data = v ? (mem_addr ^ salt) : $urandom;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.instr_ready   = rdy;
    bus.imem_rvalid   = v;
    bus.imem_rdata    = data;
    @(negedge clk);
    cyc++;
    exp_req = !m_inflight && (m_q.size() < DEPTH) && !br;
    check_val("imem_req", bus.imem_req, exp_req);
    check_val("imem_addr", bus.imem_addr, m_pc);
    check_val("instr_valid", bus.instr_valid, m_q.size() != 0);
    check_val("fifo_count", bus.fifo_count, m_q.size());
    if (m_q.size() != 0) begin
      check_val("instr_pc", bus.instr_pc, m_q[0].pc);
      check_val("instr", bus.instr, m_q[0].instr);
    end
    if (bus.imem_req && first_req < 0) first_req = cyc;
    if (bus.instr_valid && first_valid < 0) first_valid = cyc;

    pop = (m_q.size() != 0) && rdy;
    if (v) m_inflight = 1'b0;
    if (br) begin
      m_q.delete();
      m_epoch++;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (v && m_req_epoch == m_epoch)
        m_q.push_back(fetch_entry_t'{pc: m_req_addr, instr: data});
      if (exp_req) begin
        m_inflight  = 1'b1;
        m_req_addr  = m_pc;
        m_req_epoch = m_epoch;
        m_pc        = m_pc + 32'd4;
      end
    end

    if (v) mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
    if (bus.imem_req) begin
      mem_busy = 1'b1;
      mem_addr = bus.imem_addr;
      mem_lat  = $urandom_range(lat_max, lat_min) - 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready   = 1'b0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    salt = 32'h0; lat_min = 1; lat_max = 1;
    m_epoch = 0; m_req_epoch = 0; m_req_addr = '0; mem_lat = 0; mem_addr = '0;
    model_reset();
    cyc = 0; first_req = -1; first_valid = -1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Sequential fetch with 1-cycle memory returning its own address.
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check_val("first_valid_latency", 64'(first_valid - first_req), 64'd2);

    // Backpressure fills the queue and stops requests.
    repeat (14) step(1'b0, 32'h0, 1'b0);
    check_val("full_count", bus.fifo_count, DEPTH);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // Redirect while a slow request is in flight.
    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1);
      found = m_inflight && mem_busy && (mem_lat > 0);
    end
    check_val("found_inflight", found, 1'b1);
    step(1'b1, 32'h0000_0103, 1'b1);
    check_val("flush_count", bus.fifo_count, 0);
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response.
    lat_min = 1; lat_max = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1);
      found = mem_busy && (mem_lat == 0);
    end
    check_val("found_resp_cycle", found, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset with three queued entries and a request in flight.
    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      found = (m_q.size() == 3) && m_inflight;
    end
    check_val("found_three_queued", found, 1'b1);
    #1 rst = 1'b1;
    bus.imem_rvalid  = 1'b0;
    bus.branch_taken = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Random traffic: variable latency, random redirects and decode stalls.
    lat_min = 1; lat_max = 3; salt = $urandom;
    repeat (800) step($urandom_range(99, 0) < 8, $urandom, $urandom_range(99, 0) < 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
